// File: rtl/bcd2exce.sv
// Packed-BCD to excess-3 converter: each nibble gets +3, digits > 9 are flagged and zeroed.
// Latency: one cycle from in_valid to out_valid; results held while idle.
// No backpressure: one result per cycle, never stalls. Optional BCD2EXCE_DECODE_EN adds dir (1 = excess-3 to BCD).
module bcd2exce #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
`ifdef BCD2EXCE_DECODE_EN
  input  logic                  dir,
`endif
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   exce,
  output logic                  err,
  output logic [DIGITS-1:0]     digit_err
);

  localparam int W = 4 * DIGITS;

  // Converts one nibble; returns {error, result}. A bad code yields a zero nibble.
  function automatic logic [4:0] conv_nib(input logic [3:0] d, input logic dec);
    logic [4:0] r;
    r = 5'b1_0000;
    if (!dec) begin
      if (d <= 4'd9) r = {1'b0, d + 4'd3};
    end else begin
      if (d >= 4'd3 && d <= 4'hC) r = {1'b0, d - 4'd3};
    end
    return r;
  endfunction

  logic dec_sel;
`ifdef BCD2EXCE_DECODE_EN
  assign dec_sel = dir;
`else
  assign dec_sel = 1'b0;
`endif

  logic [W-1:0]      conv_exce;
  logic [DIGITS-1:0] conv_derr;

  // Per-digit conversion; digits never interact, so no carry crosses nibbles.
  always_comb begin
    logic [4:0] r;
    conv_exce = '0;
    conv_derr = '0;
    r         = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r                  = conv_nib(bcd[4*i +: 4], dec_sel);
      conv_exce[4*i +: 4] = r[3:0];
      conv_derr[i]       = r[4];
    end
  end

  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      exce_q, exce_d;
  logic              err_q, err_d;
  logic [DIGITS-1:0] digit_err_q, digit_err_d;

  // Next-state: load on in_valid, otherwise hold data and drop valid.
  always_comb begin
    out_valid_d = in_valid;
    exce_d      = exce_q;
    err_d       = err_q;
    digit_err_d = digit_err_q;
    if (in_valid) begin
      exce_d      = conv_exce;
      digit_err_d = conv_derr;
      err_d       = |conv_derr;
    end
  end

  // Output register with synchronous active-low reset that wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      exce_q      <= '0;
      err_q       <= 1'b0;
      digit_err_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      exce_q      <= exce_d;
      err_q       <= err_d;
      digit_err_q <= digit_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign exce      = exce_q;
  assign err       = err_q;
  assign digit_err = digit_err_q;

endmodule

// File: tb/tb_bcd2exce.sv
// Bench for bcd2exce: directed vectors with hand-computed results, queue-based scoreboard.
module tb_bcd2exce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic        out_valid;
  logic [15:0] exce;
  logic        err;
  logic [3:0]  digit_err;
`ifdef BCD2EXCE_DECODE_EN
  logic        dir = 1'b0;
`endif

  bcd2exce #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
`ifdef BCD2EXCE_DECODE_EN
    .dir       (dir),
`endif
    .bcd       (bcd),
    .out_valid (out_valid),
    .exce      (exce),
    .err       (err),
    .digit_err (digit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] exce;
    logic [3:0]  derr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  logic done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Present one input for one edge; an accepted vector queues its expected result.
  task automatic step(input logic v, input logic [15:0] b, input logic [15:0] ee, input logic [3:0] ed);
    in_valid = v;
    bcd      = b;
    if (v && rst_n) begin
      exp_q.push_back('{exce: ee, derr: ed, err: |ed});
      pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result is popped and compared, mid-cycle.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          popped++;
          check("exce", 32'(exce), 32'(e.exce));
          check("digit_err", 32'(digit_err), 32'(e.derr));
          check("err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    // Reset with in_valid high: reset must win.
    rst_n = 1'b0;
    step(1'b1, 16'h1234, 16'h0, 4'h0);
    step(1'b1, 16'h1234, 16'h0, 4'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_exce", 32'(exce), 32'h0000);
    check("rst_err", 32'(err), 32'd0);
    check("rst_digit_err", 32'(digit_err), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 16'h0, 4'h0);

    // Back-to-back encode stream.
    step(1'b1, 16'h0000, 16'h3333, 4'h0);
    step(1'b1, 16'h0010, 16'h3343, 4'h0);
    check("stream_valid_0", 32'(out_valid), 32'd1);
    step(1'b1, 16'h0025, 16'h3358, 4'h0);
    check("stream_valid_1", 32'(out_valid), 32'd1);
    step(1'b1, 16'h0039, 16'h336C, 4'h0);
    step(1'b1, 16'h0047, 16'h337A, 4'h0);
    step(1'b1, 16'h0058, 16'h338B, 4'h0);
    step(1'b1, 16'h0069, 16'h339C, 4'h0);
    step(1'b1, 16'h9999, 16'hCCCC, 4'h0);
    check("stream_valid_last", 32'(out_valid), 32'd1);
    step(1'b1, 16'h1A2F, 16'h4050, 4'b0101);
    step(1'b1, 16'hF000, 16'h0333, 4'b1000);
    step(1'b0, 16'h0000, 16'h0, 4'h0);

    // Single pulse then idle: data holds, valid drops.
    step(1'b1, 16'h0025, 16'h3358, 4'h0);
    check("pulse_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h9A9A, 16'h0, 4'h0);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_hold_exce", 32'(exce), 32'h3358);
      check("idle_hold_err", 32'(err), 32'd0);
    end

    // Reset on the cycle after an accepted vector.
    step(1'b1, 16'h0047, 16'h337A, 4'h0);
    rst_n = 1'b0;
    step(1'b1, 16'h0058, 16'h0, 4'h0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_exce", 32'(exce), 32'h0000);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 16'h0, 4'h0);

`ifdef BCD2EXCE_DECODE_EN
    dir = 1'b1;
    step(1'b1, 16'h339C, 16'h0069, 4'h0);
    step(1'b1, 16'h3D32, 16'h0000, 4'b0101);
    step(1'b1, 16'hCCCC, 16'h9999, 4'h0);
    dir = 1'b0;
    step(1'b1, 16'h0069, 16'h339C, 4'h0);
    step(1'b0, 16'h0000, 16'h0, 4'h0);
`endif

    step(1'b0, 16'h0000, 16'h0, 4'h0);
    step(1'b0, 16'h0000, 16'h0, 4'h0);
    check("results_seen", 32'(popped), 32'(pushed));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
